// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - req/ack memory bus between the access sequencer and unified memory
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              Mem_Req;
   logic              Mem_We;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [DATA_W-1:0] Mem_WData;
   logic [DATA_W-1:0] Mem_RData;
   logic              Mem_Ack;

   // Sequencer side: issues the request, receives data and ack.
   modport master (
      output Mem_Req, Mem_We, Mem_Addr, Mem_WData,
      input  Mem_RData, Mem_Ack
   );

   // Memory side.
   modport slave (
      input  Mem_Req, Mem_We, Mem_Addr, Mem_WData,
      output Mem_RData, Mem_Ack
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory access sequencer with IR/MDR and stall (optional MEM_ALIGN_CHECK_EN)
module mem_access_ctrl #(
   parameter int                 DATA_W  = 32,
   parameter int                 ADDR_W  = 32,
   parameter int                 TIMEOUT = 16,
   parameter logic [DATA_W-1:0]  IR_RST  = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              MemRd,
   input  logic              MemWr,
   input  logic              IorD,
   input  logic              IRWr,
   input  logic [ADDR_W-1:0] PC,
   input  logic [ADDR_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] B,
   mem_access_ctrl_if.master bus,
   output logic [DATA_W-1:0] IR,
   output logic [DATA_W-1:0] MDR,
   output logic              Stall,
   output logic              BusErr
);

   localparam int                CNT_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] POISON = DATA_W'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT             state;
   logic [CNT_W-1:0]  waitCnt;
   logic              pending;
   logic [ADDR_W-1:0] selAddr;
   logic              misaligned;

   assign pending = MemRd | MemWr;
   assign selAddr = IorD ? ALUOut : PC;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (selAddr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Stall freezes the control unit from the issue cycle through the last BUSY cycle;
   // forced low while reset is held so nothing downstream is gated during reset.
   assign Stall = RST_n & (((state == IDLE) & pending) | (state == BUSY));

   // Sequencer FSM: issue, wait for ack or timeout, then one DONE cycle to let the control unit advance.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state         <= IDLE;
         bus.Mem_Req   <= 1'b0;
         bus.Mem_We    <= 1'b0;
         bus.Mem_Addr  <= '0;
         bus.Mem_WData <= '0;
         MDR           <= '0;
         IR            <= IR_RST;
         BusErr        <= 1'b0;
         waitCnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  if (misaligned) begin
                     // Misaligned access never reaches the bus; a read gets poison data.
                     BusErr <= 1'b1;
                     if (!MemWr) MDR <= POISON;
                     state <= DONE;
                  end else begin
                     bus.Mem_Addr  <= selAddr;
                     bus.Mem_WData <= B;
                     bus.Mem_We    <= MemWr;
                     bus.Mem_Req   <= 1'b1;
                     waitCnt       <= '0;
                     state         <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (bus.Mem_Ack) begin
                  bus.Mem_Req <= 1'b0;
                  if (!bus.Mem_We) begin
                     MDR <= bus.Mem_RData;
                     if (IRWr) IR <= bus.Mem_RData;
                  end
                  state <= DONE;
               end else if (waitCnt == CNT_MAX) begin
                  // Abort: memory never answered. IR keeps its previous instruction.
                  bus.Mem_Req <= 1'b0;
                  BusErr      <= 1'b1;
                  if (!bus.Mem_We) MDR <= POISON;
                  state <= DONE;
               end else begin
                  waitCnt <= waitCnt + CNT_W'(1);
               end
            end
            DONE: begin
               // Strobes are still asserted by the same control state here; ignore them.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        MemRd, MemWr, IorD, IRWr;
   logic [31:0] PC, ALUOut, B;
   logic [31:0] IR, MDR;
   logic        Stall, BusErr;

   int checks   = 0;
   int failures = 0;

   mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_access_ctrl #(
      .DATA_W(32), .ADDR_W(32), .TIMEOUT(16), .IR_RST(32'h0000_0000)
   ) dut (
      .CLK(CLK), .RST_n(RST_n),
      .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD), .IRWr(IRWr),
      .PC(PC), .ALUOut(ALUOut), .B(B),
      .bus(bus.master),
      .IR(IR), .MDR(MDR), .Stall(Stall), .BusErr(BusErr)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   initial begin
      RST_n = 1'b0;
      MemRd = 1'b1; MemWr = 1'b0; IorD = 1'b0; IRWr = 1'b0;
      PC = '0; ALUOut = '0; B = '0;
      bus.Mem_Ack = 1'b0; bus.Mem_RData = '0;

      // Reset state, with a read strobe present to show Stall stays low in reset
      mid();
      chk("rst_req",   {31'd0, bus.Mem_Req}, 32'd0);
      chk("rst_we",    {31'd0, bus.Mem_We},  32'd0);
      chk("rst_addr",  bus.Mem_Addr,  32'd0);
      chk("rst_wdata", bus.Mem_WData, 32'd0);
      chk("rst_ir",    IR,  32'd0);
      chk("rst_mdr",   MDR, 32'd0);
      chk("rst_buserr",{31'd0, BusErr}, 32'd0);
      chk("rst_stall", {31'd0, Stall},  32'd0);
      nxt();
      MemRd = 1'b0;
      RST_n = 1'b1;
      nxt();

      // Fetch with immediate ack
      PC = 32'h0000_0040; MemRd = 1'b1; IRWr = 1'b1; IorD = 1'b0;
      mid();
      chk("f_issue_stall", {31'd0, Stall}, 32'd1);
      chk("f_issue_req",   {31'd0, bus.Mem_Req}, 32'd0);
      nxt();
      bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'h8C22_0004;
      mid();
      chk("f_busy_req",   {31'd0, bus.Mem_Req}, 32'd1);
      chk("f_busy_addr",  bus.Mem_Addr, 32'h0000_0040);
      chk("f_busy_we",    {31'd0, bus.Mem_We}, 32'd0);
      chk("f_busy_stall", {31'd0, Stall}, 32'd1);
      nxt();
      bus.Mem_Ack = 1'b0; bus.Mem_RData = 32'h0;
      mid();
      chk("f_done_stall", {31'd0, Stall}, 32'd0);
      chk("f_done_req",   {31'd0, bus.Mem_Req}, 32'd0);
      chk("f_done_ir",    IR,  32'h8C22_0004);
      chk("f_done_mdr",   MDR, 32'h8C22_0004);
      nxt();
      MemRd = 1'b0; IRWr = 1'b0;
      mid();
      chk("f_idle_stall", {31'd0, Stall}, 32'd0);
      nxt();
      mid();
      chk("f_idle_req", {31'd0, bus.Mem_Req}, 32'd0);

      // Store with five wait cycles; B changes mid-transaction and must not reach the bus
      nxt();
      IorD = 1'b1; ALUOut = 32'h0000_0100; B = 32'hCAFE_F00D; MemWr = 1'b1;
      mid();
      chk("s_issue_stall", {31'd0, Stall}, 32'd1);
      nxt();
      B = 32'h1111_2222;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) bus.Mem_Ack = 1'b1;
         mid();
         chk($sformatf("s_busy%0d_req", i),   {31'd0, bus.Mem_Req}, 32'd1);
         chk($sformatf("s_busy%0d_we", i),    {31'd0, bus.Mem_We},  32'd1);
         chk($sformatf("s_busy%0d_wdata", i), bus.Mem_WData, 32'hCAFE_F00D);
         chk($sformatf("s_busy%0d_addr", i),  bus.Mem_Addr,  32'h0000_0100);
         nxt();
      end
      bus.Mem_Ack = 1'b0;
      mid();
      chk("s_done_req",   {31'd0, bus.Mem_Req}, 32'd0);
      chk("s_done_stall", {31'd0, Stall}, 32'd0);
      chk("s_done_ir",    IR,  32'h8C22_0004);
      chk("s_done_mdr",   MDR, 32'h8C22_0004);
      nxt();
      MemWr = 1'b0;
      nxt();

      // Timeout on a read: 16 BUSY cycles, then abort
      IorD = 1'b1; ALUOut = 32'h0000_0200; MemRd = 1'b1; IRWr = 1'b1;
      nxt();
      for (int i = 0; i < 16; i++) begin
         mid();
         chk($sformatf("t_busy%0d_req", i),   {31'd0, bus.Mem_Req}, 32'd1);
         chk($sformatf("t_busy%0d_stall", i), {31'd0, Stall}, 32'd1);
         nxt();
      end
      mid();
      chk("t_done_req",    {31'd0, bus.Mem_Req}, 32'd0);
      chk("t_done_stall",  {31'd0, Stall}, 32'd0);
      chk("t_done_buserr", {31'd0, BusErr}, 32'd1);
      chk("t_done_mdr",    MDR, 32'hDEAD_BEEF);
      chk("t_done_ir",     IR,  32'h8C22_0004);
      nxt();
      MemRd = 1'b0; IRWr = 1'b0;
      nxt();

      // Next access after timeout proceeds normally
      IorD = 1'b0; PC = 32'h0000_0044; MemRd = 1'b1; IRWr = 1'b1;
      nxt();
      bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'h1234_5678;
      nxt();
      bus.Mem_Ack = 1'b0;
      mid();
      chk("n_ir",     IR,  32'h1234_5678);
      chk("n_mdr",    MDR, 32'h1234_5678);
      chk("n_buserr", {31'd0, BusErr}, 32'd1);
      nxt();
      MemRd = 1'b0; IRWr = 1'b0;
      nxt();

      // Reset on the third BUSY cycle, then a late ack
      PC = 32'h0000_0048; MemRd = 1'b1; IRWr = 1'b1;
      nxt();
      nxt();
      nxt();
      mid();
      chk("r_busy3_req", {31'd0, bus.Mem_Req}, 32'd1);
      RST_n = 1'b0;
      MemRd = 1'b0; IRWr = 1'b0;
      #1;
      chk("r_async_req",    {31'd0, bus.Mem_Req}, 32'd0);
      chk("r_async_stall",  {31'd0, Stall}, 32'd0);
      chk("r_async_ir",     IR, 32'h0000_0000);
      chk("r_async_buserr", {31'd0, BusErr}, 32'd0);
      nxt();
      RST_n = 1'b1;
      bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'hFFFF_FFFF;
      nxt();
      bus.Mem_Ack = 1'b0;
      mid();
      chk("r_late_ir",  IR,  32'h0000_0000);
      chk("r_late_mdr", MDR, 32'h0000_0000);
      chk("r_late_req", {31'd0, bus.Mem_Req}, 32'd0);
      nxt();

      // MemRd and MemWr together: write; stray acks in DONE and IDLE
      IorD = 1'b0; PC = 32'h0000_0060; B = 32'h55AA_55AA; MemRd = 1'b1; MemWr = 1'b1; IRWr = 1'b1;
      nxt();
      bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'h7777_7777;
      mid();
      chk("w2_we",    {31'd0, bus.Mem_We}, 32'd1);
      chk("w2_req",   {31'd0, bus.Mem_Req}, 32'd1);
      chk("w2_wdata", bus.Mem_WData, 32'h55AA_55AA);
      nxt();
      mid();
      chk("w2_done_stall", {31'd0, Stall}, 32'd0);
      chk("w2_done_mdr",   MDR, 32'h0000_0000);
      chk("w2_done_ir",    IR,  32'h0000_0000);
      nxt();
      MemRd = 1'b0; MemWr = 1'b0; IRWr = 1'b0;
      nxt();
      bus.Mem_Ack = 1'b0;
      mid();
      chk("w2_idle_req", {31'd0, bus.Mem_Req}, 32'd0);
      chk("w2_idle_mdr", MDR, 32'h0000_0000);
      chk("w2_idle_ir",  IR,  32'h0000_0000);
      nxt();

      // Misaligned data load at 0x102
      IorD = 1'b1; ALUOut = 32'h0000_0102; MemRd = 1'b1;
      mid();
      chk("a_issue_stall", {31'd0, Stall}, 32'd1);
      nxt();
`ifdef MEM_ALIGN_CHECK_EN
      mid();
      chk("a_done_req",    {31'd0, bus.Mem_Req}, 32'd0);
      chk("a_done_stall",  {31'd0, Stall}, 32'd0);
      chk("a_done_buserr", {31'd0, BusErr}, 32'd1);
      chk("a_done_mdr",    MDR, 32'hDEAD_BEEF);
      chk("a_done_ir",     IR,  32'h0000_0000);
      nxt();
      MemRd = 1'b0;
      nxt();
`else
      bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'hA5A5_A5A5;
      mid();
      chk("a_busy_req",  {31'd0, bus.Mem_Req}, 32'd1);
      chk("a_busy_addr", bus.Mem_Addr, 32'h0000_0102);
      nxt();
      bus.Mem_Ack = 1'b0;
      mid();
      chk("a_done_mdr",    MDR, 32'hA5A5_A5A5);
      chk("a_done_buserr", {31'd0, BusErr}, 32'd0);
      nxt();
      MemRd = 1'b0;
      nxt();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access sequencer between the multi-cycle control unit and a variable-latency unified instruction/data memory.
- Consumes the control unit's MemRd, MemWr, IorD and IRWr strobes, plus the PC, ALUOut and B datapath values.
- Runs a req/ack bus transaction and holds IR and MDR.
- Raises Stall, which freezes the control unit's state register and gates the PC and register-file write enables until the transaction completes.

Parameters:
- DATA_W, 32, data and instruction width.
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, maximum BUSY cycles waiting for Mem_Ack before the access is aborted (must be at least 1).
- IR_RST, 32'h0000_0000, reset value of IR (a NOP).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_n  in  1  asynchronous active-low reset.
- MemRd  in  1  read strobe from the control unit.
- MemWr  in  1  write strobe from the control unit.
- IorD  in  1  address select: 0 = PC, 1 = ALUOut.
- IRWr  in  1  load IR with the read data.
- PC  in  ADDR_W  fetch address.
- ALUOut  in  ADDR_W  data address.
- B  in  DATA_W  store data.
- Mem_Req  out  1  bus request, held until acknowledged.
- Mem_We  out  1  1 = write, 0 = read; valid while Mem_Req is high.
- Mem_Addr  out  ADDR_W  registered bus address.
- Mem_WData  out  DATA_W  registered store data.
- Mem_RData  in  DATA_W  read data; valid in the Mem_Ack cycle.
- Mem_Ack  in  1  single-cycle completion pulse.
- IR  out  DATA_W  instruction register.
- MDR  out  DATA_W  memory data register.
- Stall  out  1  hold the control-unit state, PCWr and RegWr.
- BusErr  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - state = IDLE; Mem_Req = 0, Mem_We = 0; Mem_Addr, Mem_WData and MDR = 0; IR = IR_RST; BusErr = 0; timeout counter = 0.
  - Stall is combinational and therefore 0 during reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - An access is pending when MemRd | MemWr.
  - On a pending access: Stall = 1 combinationally in the same cycle.
  - At the clock edge: Mem_Addr <= IorD ? ALUOut : PC; Mem_WData <= B; Mem_We <= MemWr; Mem_Req <= 1; counter <= 0; go to BUSY.
  - MemRd and MemWr both high: treated as a write (MemWr has priority); no error is flagged.
- BUSY:
  - Stall = 1; Mem_Req, Mem_We, Mem_Addr and Mem_WData are held stable.
  - Mem_Ack = 1: Mem_Req <= 0. For a read, MDR <= Mem_RData, and IR <= Mem_RData if IRWr is sampled high in that cycle. Go to DONE.
  - Mem_Ack = 0: counter increments. When counter == TIMEOUT-1 with no ack: Mem_Req <= 0, BusErr <= 1, MDR <= 32'hDEAD_BEEF on a read (IR unchanged), go to DONE.
- DONE:
  - Stall = 0, so the control unit advances at this edge.
  - MemRd/MemWr are still visible this cycle (same control-unit state) and are ignored; no new access starts.
  - Always go to IDLE next cycle.
- Minimum access time: 3 cycles (issue, BUSY with immediate ack, DONE).
- Maximum access time: TIMEOUT + 2 cycles.
- Mem_Ack outside BUSY is ignored and changes no state.
- Each of IR and MDR changes only on a completed read, on timeout (MDR only) or on reset.
- Counter width is $clog2(TIMEOUT+1); it never wraps because it is bounded by TIMEOUT-1.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a pending access whose selected address has bits [1:0] != 2'b00 issues no bus request.
  - The block goes directly to DONE with BusErr <= 1 and Stall = 1 for that one issue cycle only.
  - MDR <= 32'hDEAD_BEEF on a read; IR is not written.
- Not defined: the address is passed through unchecked; low bits reach the bus unchanged.

Test Plan:
- Reset, then fetch: PC=0x0000_0040, MemRd=1, IRWr=1, IorD=0, memory acks in the first BUSY cycle with 0x8C22_0004 -> Mem_Addr=0x40, Mem_We=0; Stall high for 2 cycles; IR=MDR=0x8C22_0004; back in IDLE on cycle 4.
- Store: IorD=1, ALUOut=0x100, B=0xCAFE_F00D, MemWr=1, ack after 5 wait cycles -> Mem_Req high for 6 cycles with Mem_We=1 and Mem_WData constant; IR and MDR unchanged.
- Timeout: TIMEOUT=16, read with Mem_Ack never asserted -> Mem_Req drops after 16 BUSY cycles; BusErr=1 and stays 1; MDR=0xDEAD_BEEF; the next access proceeds normally.
- Reset mid-BUSY: assert RST_n=0 on the 3rd BUSY cycle -> Mem_Req=0 and Stall=0 immediately; IR=IR_RST. A late Mem_Ack after reset is released is ignored.
- MemRd=MemWr=1 together -> write performed (Mem_We=1); a stray Mem_Ack in IDLE or DONE changes nothing.
- With MEM_ALIGN_CHECK_EN defined, ALUOut=0x102 load -> no Mem_Req; BusErr=1; access completes in 2 cycles. Without the macro, Mem_Addr=0x102 appears on the bus.
